// File: rtl/alt_trigout_ts_capture.sv
// Purpose : qualify channel/external trigger pulses with enables and WR status, timestamp each
//           accepted event with WR time and queue {sec, cycles, mask} in a show-ahead FIFO.
// Latency : an event in cycle n is visible on the head outputs from cycle n+1; pop shows next entry next cycle.
// Backpr. : no stall on the trigger side; an event arriving with the FIFO full is dropped and flags overflow_o.
//
// Ports
//   clk_i, rst_n_i             : clock, synchronous active-low reset
//   ch_trig_i, ext_trig_i      : single-cycle trigger pulses (4 channels + external)
//   ch_enable_i, ext_enable_i  : per-source enables
//   wr_enable_i, wr_valid_i    : White Rabbit enabled / time valid; both needed to accept an event
//   tm_tai_i, tm_cycles_i      : WR time sampled on an accepted event
//   ts_rd_i                    : pop strobe for the head entry
//   ts_present_o, ts_sec_o, ts_cycles_o, ch_mask_o, ext_mask_o : registered head entry, zero when empty
//   overflow_o, clr_overflow_i : sticky dropped-event flag and its clear
module alt_trigout_ts_capture #(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned HOLDOFF    = 8
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [3:0]  ch_trig_i,
    input  logic        ext_trig_i,
    input  logic [3:0]  ch_enable_i,
    input  logic        ext_enable_i,
    input  logic        wr_enable_i,
    input  logic        wr_valid_i,
    input  logic [39:0] tm_tai_i,
    input  logic [27:0] tm_cycles_i,
    input  logic        ts_rd_i,
    output logic        ts_present_o,
    output logic [39:0] ts_sec_o,
    output logic [27:0] ts_cycles_o,
    output logic [3:0]  ch_mask_o,
    output logic        ext_mask_o,
    output logic        overflow_o,
    input  logic        clr_overflow_i
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam logic [CW-1:0] HOLD_LOAD = (HOLDOFF > 0) ? CW'(HOLDOFF - 1) : '0;
    localparam logic [AW:0]   DEPTH_CNT = (AW + 1)'(FIFO_DEPTH);

    typedef struct packed {
        logic [39:0] sec;
        logic [27:0] cycles;
        logic        ext;
        logic [3:0]  ch;
    } entry_t;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   hold_cnt_q, hold_cnt_d;

    entry_t          mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d, remaining;
    entry_t          head_q, head_d, new_entry;
    logic            present_q;
    logic            overflow_q, overflow_d;

    logic [4:0]      q_mask;
    logic            evt, do_pop, do_push, drop;

    // Qualification is purely combinational so enable/WR changes act in the same cycle.
    assign q_mask = {ext_trig_i & ext_enable_i, ch_trig_i & ch_enable_i};
    assign evt    = (state_q == S_IDLE) && (|q_mask) && wr_enable_i && wr_valid_i;

    // A pop on an empty FIFO is ignored, which also makes empty push+pop a plain push.
    assign do_pop  = ts_rd_i && (count_q != '0);
    // Full FIFO still accepts when the head leaves in the same cycle.
    assign do_push = evt && ((count_q < DEPTH_CNT) || do_pop);
    assign drop    = evt && !do_push;

    assign new_entry = '{sec: tm_tai_i, cycles: tm_cycles_i, ext: q_mask[4], ch: q_mask[3:0]};

    assign remaining = count_q - (AW + 1)'(do_pop);
    assign count_d   = remaining + (AW + 1)'(do_push);
    assign rd_ptr_d  = rd_ptr_q + AW'(do_pop);

    // Next head: when nothing older survives this cycle, the entry being pushed becomes the head
    // directly (memory is written at the same edge, so it cannot be read from there yet).
    always_comb begin
        head_d = '0;
        if (count_d == '0) begin
            head_d = '0;
        end else if (remaining == '0) begin
            head_d = new_entry;
        end else begin
            head_d = mem[rd_ptr_d];
        end
    end

    // Dead-time FSM: HOLD lasts exactly HOLDOFF cycles after the event cycle.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (evt && (HOLDOFF > 0)) begin
                    state_d    = S_HOLD;
                    hold_cnt_d = HOLD_LOAD;
                end
            end
            S_HOLD: begin
                if (hold_cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    hold_cnt_d = hold_cnt_q - CW'(1);
                end
            end
            default: begin
                state_d    = S_IDLE;
                hold_cnt_d = '0;
            end
        endcase
    end

    // Set beats clear when both happen in one cycle.
    always_comb begin
        overflow_d = overflow_q;
        if (drop) begin
            overflow_d = 1'b1;
        end else if (clr_overflow_i) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q    <= S_IDLE;
            hold_cnt_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            head_q     <= '0;
            present_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            wr_ptr_q   <= wr_ptr_q + AW'(do_push);
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            head_q     <= head_d;
            present_q  <= (count_d != '0);
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset: validity is tracked entirely by the pointers and count.
    always_ff @(posedge clk_i) begin
        if (rst_n_i && do_push) begin
            mem[wr_ptr_q] <= new_entry;
        end
    end

    assign ts_present_o = present_q;
    assign ts_sec_o     = head_q.sec;
    assign ts_cycles_o  = head_q.cycles;
    assign ch_mask_o    = head_q.ch;
    assign ext_mask_o   = head_q.ext;
    assign overflow_o   = overflow_q;

endmodule
